// File: rtl/load_store_unit.sv
// Load/store unit: core-side handshake to a byte-addressed little-endian data memory, with SB/SH done as read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses are reported as errors instead of being performed.
module load_store_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t      state, state_next;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [15:0] lat_wdata;
  logic        accept, f3_bad, misaligned, req_bad, is_sw;
  logic [1:0]  size_m1;
  logic [ADDR_W:0] last_byte;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;
  assign is_sw  = lat_we && (lat_f3 == 3'd2);

  // Last byte is computed one bit wider so an access wrapping past the top of the address space is caught.
  always_comb begin
    size_m1 = 2'd3;
    if (req_funct3[1:0] == 2'd0)
      size_m1 = 2'd0;
    else if (req_funct3[1:0] == 2'd1)
      size_m1 = 2'd1;
    last_byte = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, size_m1};
    if (req_we)
      f3_bad = (req_funct3 > 3'd2);
    else
      f3_bad = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
`else
  assign misaligned = 1'b0;
`endif

  assign req_bad = f3_bad || misaligned || (last_byte >= MEM_LIMIT);
  assign merged  = lat_f3[0] ? {mem_rdata[31:16], lat_wdata} : {mem_rdata[31:8], lat_wdata[7:0]};

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    extend = {{24{d[7]}}, d[7:0]};
      3'd1:    extend = {{16{d[15]}}, d[15:0]};
      3'd2:    extend = d;
      3'd4:    extend = {24'h0, d[7:0]};
      3'd5:    extend = {16'h0, d[15:0]};
      default: extend = 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_next = req_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_we     = is_sw;
        state_next = (lat_we && !is_sw) ? WRITE : RESP;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mem_addr doubles as the latched request address; errored requests leave the memory port untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_f3     <= 3'd0;
      lat_wdata  <= 16'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_wdata <= req_wdata[15:0];
            if (req_bad) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              mem_addr <= req_addr;
              if (req_we && (req_funct3 == 3'd2))
                mem_wdata <= req_wdata;
            end
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            resp_rdata <= extend(lat_f3, mem_rdata);
            resp_err   <= 1'b0;
          end else if (is_sw) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end else begin
            mem_wdata <= merged;
          end
        end
        WRITE: begin
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model; define MISALIGN_TRAP_EN to match a trapping build.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int numChecks = 0;
  int numFails  = 0;
  int memWrites = 0;
  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] rdByte(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a[9:0]] : 8'h00;
  endfunction

  assign mem_rdata = {rdByte(mem_addr + 32'd3), rdByte(mem_addr + 32'd2),
                      rdByte(mem_addr + 32'd1), rdByte(mem_addr)};

  // Memory writes all four bytes at mem_addr on every enabled edge.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if ({1'b0, mem_addr} + 33'(i) < 33'd1024)
          mem[10'(mem_addr + 32'(i))] = mem_wdata[8*i +: 8];
      memWrites = memWrites + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr,
                               input int expLat, input int expWrites);
    int lat;
    int w0;
    @(negedge clk);
    checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    w0  = memWrites;
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 12);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " rdata"}, resp_rdata, expData);
    checkOutput({tag, " err"}, 32'(resp_err), 32'(expErr));
    checkOutput({tag, " writes"}, 32'(memWrites - w0), 32'(expWrites));
    @(posedge clk); #1;
    checkOutput({tag, " pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic loadBase();
    mem[16] = 8'hBB; mem[17] = 8'hAA; mem[18] = 8'h99; mem[19] = 8'h88;
  endtask

  initial begin
    logic [6:0] readyPat;
    int w0;
    int respCount;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rst ready", 32'(req_ready), 32'd1);
    checkOutput("rst resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'h0);
    checkOutput("rst mem_wdata", mem_wdata, 32'h0);

    loadBase();
    mem[1020] = 8'h01; mem[1021] = 8'h02; mem[1022] = 8'h03; mem[1023] = 8'h04;

    applyStimulus("LW 10",  1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0);
    applyStimulus("LB 10",  1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0);
    applyStimulus("LBU 10", 1'b0, 3'd4, 32'h10, 32'h0, 32'h000000BB, 1'b0, 2, 0);
    applyStimulus("LH 12",  1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0);
    applyStimulus("LHU 12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 0);
    applyStimulus("SB 10",  1'b1, 3'd0, 32'h10, 32'h12345678, 32'h0, 1'b0, 3, 1);
    applyStimulus("LW 10 after SB", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8899AA78, 1'b0, 2, 0);

    // SH then SW with req_valid held high across the SH transaction.
    readyPat = 7'b1001000;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h0000CAFE;
    w0 = memWrites;
    respCount = 0;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; end
      if (e == 4) req_valid = 1'b0;
      respCount += int'(resp_valid);
      checkOutput($sformatf("b2b ready e%0d", e), 32'(req_ready), 32'(readyPat[e]));
    end
    checkOutput("b2b responses", 32'(respCount), 32'd2);
    checkOutput("b2b writes", 32'(memWrites - w0), 32'd2);
    applyStimulus("LW 10 after SH", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8899CAFE, 1'b0, 2, 0);
    applyStimulus("LW 20 after SW", 1'b0, 3'd2, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    applyStimulus("LW 3FE range", 1'b0, 3'd2, 32'h3FE, 32'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus("load f3=3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus("store f3=4", 1'b1, 3'd4, 32'h10, 32'h11111111, 32'h0, 1'b1, 1, 0);
    applyStimulus("LH wrap", 1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 0);
    applyStimulus("LW 3FC", 1'b0, 3'd2, 32'h3FC, 32'h0, 32'h04030201, 1'b0, 2, 0);
    applyStimulus("LBU 3FF", 1'b0, 3'd4, 32'h3FF, 32'h0, 32'h00000004, 1'b0, 2, 0);

    // Reset while an SB sits in its write cycle.
    loadBase();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("SB write cycle mem_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst mid mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst mid resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rst mid ready", 32'(req_ready), 32'd1);
    respCount = 0;
    repeat (3) begin
      @(posedge clk); #1;
      respCount += int'(resp_valid);
    end
    checkOutput("rst mid no resp", 32'(respCount), 32'd0);

`ifdef MISALIGN_TRAP_EN
    applyStimulus("LH 11", 1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    applyStimulus("LH 11", 1'b0, 3'd1, 32'h11, 32'h0, 32'hFFFF99AA, 1'b0, 2, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
